piso_frame_rx: RTL and testbench



---
 rtl/piso_link_pkg.sv | 26 ++
 rtl/rx_out_buf.sv | 50 +++++
 rtl/piso_frame_rx.sv | 128 ++++++++++++
 tb/tb_piso_frame_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_link_pkg.sv
// Shared definitions for the PISO serial link (transmitter and receiver).
package piso_link_pkg;

  // Frame sequencer states, common to both ends of the link.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } link_state_e;

  // Line levels that delimit a frame on an idle-low line.
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Widest data word the link supports; parity helper operates on this width.
  localparam int unsigned MAX_WIDTH = 32;

  // Even-parity bit for a zero-extended data word: 1 when the word has an odd
  // number of ones, so that word plus parity bit carries an even count.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register. A load is accepted when the buffer
// is empty or is being drained on the same edge; otherwise the incoming word
// is dropped and a one-cycle overrun pulse is raised.
module rx_out_buf #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;
  logic         w_accept;
  logic         w_drop;

  // Decide whether an offered word fits: free slot, or slot emptied this edge.
  always_comb begin
    w_accept = i_load && (!r_valid || i_ready);
    w_drop   = i_load && r_valid && !i_ready;
  end

  // Holding register: load, drain on ready, otherwise keep the word stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_accept) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/piso_frame_rx.sv
// Framed serial-to-parallel receiver for the PISO link: start bit, WIDTH data
// bits MSB first, optional even parity, stop bit; good words are offered on a
// valid/ready port through a one-entry buffer.
module piso_frame_rx
  import piso_link_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  link_state_e          r_state;
  link_state_e          w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     w_shift_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_frame_err;
  logic                 w_commit;
  logic                 w_stop_bad;
  logic                 w_last_bit;
  logic                 w_perr_out;
  logic [MAX_WIDTH-1:0] w_shift_ext;
  logic [WIDTH:0]       w_buf_data;

  // Zero-extend the received word for the shared parity helper.
  always_comb begin
    w_shift_ext              = '0;
    w_shift_ext[WIDTH-1:0]   = r_shift;
    w_last_bit               = (r_cnt == CNT_W'(WIDTH - 1));
    w_perr_out               = PARITY_EN ? r_perr : 1'b0;
  end

  // Next-state and datapath updates; nothing moves unless bit_en is high.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_commit    = 1'b0;
    w_stop_bad  = 1'b0;
    if (bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (s_in == START_BIT) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = '0;
          end
        end
        DATA: begin
          w_shift_nxt = {r_shift[WIDTH-2:0], s_in};
          w_cnt_nxt   = r_cnt + 1'b1;
          if (w_last_bit) begin
            if (PARITY_EN) w_state_nxt = PAR;
            else           w_state_nxt = STOP;
          end
        end
        PAR: begin
          w_perr_nxt  = even_parity(w_shift_ext) ^ s_in;
          w_state_nxt = STOP;
        end
        STOP: begin
          // A bad stop bit returns straight to IDLE; it is never taken as a start.
          if (s_in == STOP_BIT) w_commit   = 1'b1;
          else                  w_stop_bad = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bit counter, shift register, parity flag and frame-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_perr      <= w_perr_nxt;
      r_frame_err <= w_stop_bad;
    end
  end

  // Parity flag rides alongside the data word through the output buffer.
  rx_out_buf #(
    .W (WIDTH + 1)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_commit),
    .i_data    ({r_shift, w_perr_out}),
    .i_ready   (p_ready),
    .o_data    (w_buf_data),
    .o_valid   (p_valid),
    .o_overrun (overrun)
  );

  assign p_out      = w_buf_data[WIDTH:1];
  assign parity_err = w_buf_data[0];
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_piso_frame_rx.sv
// Directed bench for piso_frame_rx with WIDTH=4 and even parity enabled.
module tb_piso_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic       s_in;
  logic [3:0] p_out;
  logic       p_valid;
  logic       p_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  piso_frame_rx #(
    .WIDTH     (4),
    .PARITY_EN (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .s_in       (s_in),
    .p_out      (p_out),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Present one line value at the falling edge; sampled at the next rising edge.
  task automatic drive(input logic b, input logic en);
    @(negedge clk);
    s_in   = b;
    bit_en = en;
  endtask

  // Seven bit-times, leftmost bit first: start, d3..d0, parity, stop.
  task automatic send(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) drive(f[i], 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1; bit_en = 1'b1; s_in = 1'b1; p_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (p_out !== 4'b0000) begin n_fail++; $display("FAIL reset_p_out got %b exp %b", p_out, 4'b0000); end
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid got %b exp 0", p_valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b exp 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    s_in = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b1);
  endtask

  task automatic test_good_frame;
    send(7'b1101110);
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid got %b exp 0", p_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_stop got %b exp 1", busy); end
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b1011) begin n_fail++; $display("FAIL good_p_out got %b exp %b", p_out, 4'b1011); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL good_parity_err got %b exp 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL good_frame_err got %b exp 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL good_overrun got %b exp 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_idle got %b exp 0", busy); end
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL good_valid_one_cycle got %b exp 0", p_valid); end
  endtask

  task automatic test_parity_error;
    send(7'b1101100);
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL perr_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b1011) begin n_fail++; $display("FAIL perr_p_out got %b exp %b", p_out, 4'b1011); end
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_parity_err got %b exp 1", parity_err); end
    drive(1'b0, 1'b1);
  endtask

  task automatic test_frame_error;
    send(7'b1011001);
    drive(1'b0, 1'b1);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse got %b exp 1", frame_err); end
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b exp 0", p_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy got %b exp 0", busy); end
    drive(1'b0, 1'b1);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_one_cycle got %b exp 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_no_restart got %b exp 0", busy); end
    send(7'b1011000);
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b0110) begin n_fail++; $display("FAIL ferr_next_p_out got %b exp %b", p_out, 4'b0110); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_next_parity got %b exp 0", parity_err); end
    drive(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_overrun;
    logic [6:0] fb;
    fb = 7'b1011000;
    p_ready = 1'b0;
    send(7'b1101110);
    drive(fb[6], 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b1011) begin n_fail++; $display("FAIL ovr_first_p_out got %b exp %b", p_out, 4'b1011); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b exp 0", overrun); end
    for (int i = 5; i >= 0; i--) drive(fb[i], 1'b1);
    drive(1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b1011) begin n_fail++; $display("FAIL ovr_hold_p_out got %b exp %b", p_out, 4'b1011); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ovr_hold_parity got %b exp 0", parity_err); end
    p_ready = 1'b1;
    drive(1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consumed got %b exp 0", p_valid); end
    p_ready = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_dropped_never got %b exp 0", p_valid); end
    p_ready = 1'b1;
  endtask

  task automatic test_bit_enable;
    logic [6:0] f;
    logic       b;
    int         clocks;
    f = 7'b1101110;
    clocks = 0;
    for (int j = 6; j >= 0; j--) begin
      b = f[j];
      for (int k = 0; k < 3; k++) begin
        if (k < 2) drive(~b, 1'b0);
        else       drive(b, 1'b1);
        n_checks++;
        if (busy !== (j != 6)) begin
          n_fail++; $display("FAIL ben_busy_hold slot %0d cyc %0d got %b exp %b", 6 - j, k, busy, (j != 6));
        end
        clocks++;
      end
    end
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL ben_early_valid got %b exp 0", p_valid); end
    drive(1'b0, 1'b0);
    n_checks++; if (clocks !== 21) begin n_fail++; $display("FAIL ben_clocks got %0d exp 21", clocks); end
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL ben_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b1011) begin n_fail++; $display("FAIL ben_p_out got %b exp %b", p_out, 4'b1011); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ben_parity got %b exp 0", parity_err); end
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL ben_consumed got %b exp 0", p_valid); end
  endtask

  task automatic test_async_reset;
    p_ready = 1'b0;
    send(7'b1101110);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b exp 1", p_valid); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b exp 0", p_valid); end
    n_checks++; if (p_out !== 4'b0000) begin n_fail++; $display("FAIL rst_async_p_out got %b exp %b", p_out, 4'b0000); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_parity got %b exp 0", parity_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b exp 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_frame_err got %b exp 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_async_overrun got %b exp 0", overrun); end
    @(negedge clk);
    reset   = 1'b0;
    s_in    = 1'b0;
    p_ready = 1'b1;
    send(7'b1011000);
    drive(1'b0, 1'b1);
    n_checks++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_valid got %b exp 1", p_valid); end
    n_checks++; if (p_out !== 4'b0110) begin n_fail++; $display("FAIL rst_after_p_out got %b exp %b", p_out, 4'b0110); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_after_parity got %b exp 0", parity_err); end
    drive(1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_error;
    test_frame_error;
    test_back_to_back_overrun;
    test_bit_enable;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
